// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory stall controller.
package dmem_pkg;

    localparam int unsigned DMEM_ADDR_W = 7;
    localparam int unsigned DMEM_DATA_W = 32;
    localparam logic [31:0] DMEM_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_timeout_cnt.sv
// BUSY-cycle counter; flags the last cycle the controller waits for an ack.
module dmem_timeout_cnt #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT) + 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_stall_ctrl.sv
// Stretches the core's single-cycle data access into a req/ack SRAM transaction,
// stalling the core until the access completes or times out.
module dmem_stall_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W = DMEM_ADDR_W,
    parameter int unsigned DATA_W = DMEM_DATA_W,
    parameter int unsigned TIMEOUT = 64,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(DMEM_ERR_DATA)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_wen,
    input  logic              core_oen,
    input  logic [ADDR_W-1:0] core_a,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    dmem_state_e       state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
    logic              err_q, err_d;
    logic              access;
    logic              cnt_clr, cnt_en, expired;

    assign access = ~core_wen | ~core_oen;

    dmem_timeout_cnt #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .expired(expired)
    );

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        core_rdata_d = core_rdata_q;
        err_d        = err_q;
        core_stall   = 1'b0;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;
        unique case (state_q)
            StIdle: begin
                core_stall = access;
                cnt_clr    = 1'b1;
                if (access) begin
                    // A write wins when both strobes are low.
                    mem_req_d   = 1'b1;
                    mem_we_d    = ~core_wen;
                    mem_addr_d  = core_a;
                    mem_wdata_d = core_wdata;
                    state_d     = StBusy;
                end
            end
            StBusy: begin
                core_stall = 1'b1;
                cnt_en     = 1'b1;
                if (mem_ack) begin
                    if (!mem_we_q) core_rdata_d = mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = StDone;
                end else if (expired) begin
                    if (!mem_we_q) core_rdata_d = ERR_DATA;
                    err_d     = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = StDone;
                end
            end
            StDone: begin
                // Core commits this cycle; its still-present access is not re-issued.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_rdata_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            core_rdata_q <= core_rdata_d;
            err_q        <= err_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign core_rdata = core_rdata_q;
    assign err        = err_q;

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Randomized transaction-level bench for dmem_stall_ctrl against a memory/latency model.
module tb_dmem_stall_ctrl;

    localparam int unsigned TIMEOUT = 8;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_wen, core_oen;
    logic [6:0]  core_a;
    logic [31:0] core_wdata, core_rdata;
    logic        core_stall;
    logic        mem_req, mem_we;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: SRAM contents plus what the core should see.
    logic [31:0] sram [128];
    logic [31:0] exp_rdata;
    logic        exp_err;

    always #5 clk = ~clk;

    dmem_stall_ctrl #(
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .core_wen  (core_wen),
        .core_oen  (core_oen),
        .core_a    (core_a),
        .core_wdata(core_wdata),
        .core_rdata(core_rdata),
        .core_stall(core_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Call at a falling edge. ack_at = BUSY cycle (1-based) that gets mem_ack; 0 = never.
    task automatic do_access(input logic wen, input logic oen, input logic [6:0] a,
                             input logic [31:0] wd, input int ack_at, input bit stray);
        int   stall_n, req_n, cyc, exp_req;
        bit   done, bad, tmo;
        logic is_wr;
        is_wr      = !wen;
        core_wen   = wen;
        core_oen   = oen;
        core_a     = a;
        core_wdata = wd;
        stall_n = 0; req_n = 0; cyc = 0; done = 0; bad = 0;
        while (!done && cyc < int'(TIMEOUT) + 8) begin
            #1;
            if (!core_stall) begin
                done = 1;
            end else begin
                stall_n++;
                if (mem_req) begin
                    req_n++;
                    if (mem_we !== is_wr || mem_addr !== a || mem_wdata !== wd) bad = 1;
                    if (req_n == ack_at) begin
                        mem_ack   = 1'b1;
                        mem_rdata = is_wr ? $urandom : sram[a];
                    end
                end
                @(negedge clk);
                mem_ack = 1'b0;
                cyc++;
            end
        end
        if (!done) begin
            check("done_reached", 32'd0, 32'd1);
            return;
        end
        tmo     = (ack_at < 1 || ack_at > int'(TIMEOUT));
        exp_req = tmo ? int'(TIMEOUT) : ack_at;
        if (tmo) begin
            exp_err = 1'b1;
            if (!is_wr) exp_rdata = ERR_DATA;
        end else if (is_wr) begin
            sram[a] = wd;
        end else begin
            exp_rdata = sram[a];
        end
        check("stall_cycles", stall_n, exp_req + 1);
        check("req_cycles", req_n, exp_req);
        check("req_fields_stable", {31'd0, bad}, 32'd0);
        check("done_rdata", core_rdata, exp_rdata);
        check("done_err", {31'd0, err}, {31'd0, exp_err});
        if (stray) begin
            mem_ack   = 1'b1;
            mem_rdata = $urandom;
        end
        @(negedge clk);
        mem_ack  = 1'b0;
        core_wen = 1'b1;
        core_oen = 1'b1;
        #1;
        check("no_reissue", {31'd0, mem_req}, 32'd0);
        check("idle_rdata", core_rdata, exp_rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   ack_at;
        logic wen, oen;
        for (int i = 0; i < 128; i++) sram[i] = $urandom;
        exp_rdata = 32'd0;
        exp_err   = 1'b0;
        rst = 1'b1; core_wen = 1'b1; core_oen = 1'b1; core_a = '0; core_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {25'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_core_rdata", core_rdata, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_stall", {31'd0, core_stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic read, immediate ack.
        sram[5] = 32'h1234_5678;
        do_access(1'b1, 1'b0, 7'h05, 32'h0, 1, 1'b0);
        // Write acked on the 4th BUSY cycle.
        do_access(1'b0, 1'b1, 7'h7F, 32'hCAFE_F00D, 4, 1'b0);
        // Read with no ack times out; err then stays set.
        do_access(1'b1, 1'b0, 7'h11, 32'h0, 0, 1'b0);
        do_access(1'b1, 1'b0, 7'h7F, 32'h0, 2, 1'b0);
        // Both strobes low is a write; stray ack in DONE then in IDLE.
        do_access(1'b0, 1'b0, 7'h22, 32'hA5A5_0001, 2, 1'b1);
        for (int i = 0; i < 2; i++) begin
            mem_ack   = 1'b1;
            mem_rdata = $urandom;
            #1;
            check("idle_ack_stall", {31'd0, core_stall}, 32'd0);
            @(negedge clk);
            mem_ack = 1'b0;
            #1;
            check("idle_ack_req", {31'd0, mem_req}, 32'd0);
            check("idle_ack_rdata", core_rdata, exp_rdata);
        end

        // Reset on the 2nd BUSY cycle, ack arrives one cycle later.
        @(negedge clk);
        core_oen = 1'b0; core_a = 7'h33;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; core_oen = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        #1;
        check("rst_mid_req", {31'd0, mem_req}, 32'd0);
        check("rst_mid_stall", {31'd0, core_stall}, 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        exp_rdata = 32'd0;
        exp_err   = 1'b0;
        check("rst_late_ack_rdata", core_rdata, 32'd0);
        check("rst_late_ack_err", {31'd0, err}, 32'd0);
        check("rst_late_ack_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);

        // Ack coinciding with the timeout cycle: ack wins.
        do_access(1'b1, 1'b0, 7'h44, 32'h0, TIMEOUT, 1'b0);
        // Back-to-back read then write with immediate acks.
        do_access(1'b1, 1'b0, 7'h7F, 32'h0, 1, 1'b0);
        do_access(1'b0, 1'b1, 7'h7F, 32'h0BAD_CAFE, 1, 1'b0);
        do_access(1'b1, 1'b0, 7'h7F, 32'h0, 1, 1'b0);

        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 2))
                0:       begin wen = 1'b0; oen = 1'b1; end
                1:       begin wen = 1'b1; oen = 1'b0; end
                default: begin wen = 1'b0; oen = 1'b0; end
            endcase
            ack_at = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
            do_access(wen, oen, 7'($urandom), $urandom, ack_at, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
